pwm_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel PWM generator.
- CHANNELS independent counters share one register-write port.
- Writes are addressed by channel index plus the existing 2-bit select code.
- Adds per-channel enable, period-synchronous (shadowed) compare/top updates, output polarity, and a period-end pulse for the interrupt/sequencing logic.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_channel.sv | 93 +++++++++
 rtl/pwm_multi.sv | 61 ++++++
 tb/tb_pwm_multi.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and helpers for the multi-channel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CMP  = 2'd1,
        SEL_TOP  = 2'd2,
        SEL_CNT  = 2'd3
    } pwm_sel_t;

    // A single-channel build still carries a 1-bit channel index.
    function automatic int pwm_ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One PWM channel: counter, shadowed compare/top, output, wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int   WIDTH = 16,
    parameter logic POL   = 1'b0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             wr_cmp,
    input  logic             wr_top,
    input  logic             wr_cnt,
    input  logic [WIDTH-1:0] d,
    output logic             out,
    output logic             wrap,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cmp_s;
    logic [WIDTH-1:0] r_top_s;
    logic [WIDTH-1:0] r_cmp_a;
    logic [WIDTH-1:0] r_top_a;
    logic             r_run;
    logic             r_out;
    logic             r_wrap;

    logic             w_start;
    logic             w_wrap;
    logic             w_load;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_cmp_a_next;
    logic [WIDTH-1:0] w_top_a_next;
    logic             w_out_next;

    // The first enabled edge opens a period at the held count without
    // advancing it, so the first enabled output cycle reflects that count.
    always_comb begin
        w_start      = en & ~r_run;
        w_wrap       = en & r_run & (r_cnt >= r_top_a);
        w_load       = ~en | w_start | w_wrap;
        w_cmp_a_next = w_load ? r_cmp_s : r_cmp_a;
        w_top_a_next = w_load ? r_top_s : r_top_a;
        if (wr_cnt) begin
            w_cnt_next = d;
        end else if (~en | w_wrap) begin
            w_cnt_next = '0;
        end else if (w_start) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + WIDTH'(1);
        end
        w_out_next = en ? ((w_cnt_next < w_cmp_a_next) ^ POL) : POL;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt   <= '0;
            r_cmp_s <= '0;
            r_top_s <= '0;
            r_cmp_a <= '0;
            r_top_a <= '0;
            r_run   <= 1'b0;
            r_out   <= POL;
            r_wrap  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_cmp_a <= w_cmp_a_next;
            r_top_a <= w_top_a_next;
            r_run   <= en;
            r_out   <= w_out_next;
            r_wrap  <= w_wrap;
            if (wr_cmp) begin
                r_cmp_s <= d;
            end
            if (wr_top) begin
                r_top_s <= d;
            end
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : CHANNELS independent PWM channels behind one shared write port.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                  WIDTH    = 16,
    parameter int                  CHANNELS = 4,
    parameter logic [CHANNELS-1:0] POL_MASK = {CHANNELS{1'b0}}
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [WIDTH-1:0]                  d,
    input  logic [1:0]                        sel,
    input  logic [pwm_ch_width(CHANNELS)-1:0] ch,
    input  logic [CHANNELS-1:0]               en,
    output logic [CHANNELS-1:0]               out,
    output logic [WIDTH-1:0]                  cnt_rd,
    output logic [CHANNELS-1:0]               wrap
);

    localparam int c_CH_W = pwm_ch_width(CHANNELS);

    pwm_sel_t         w_sel;
    logic             w_ch_ok;
    logic [WIDTH-1:0] w_cnt [CHANNELS];

    assign w_sel   = pwm_sel_t'(sel);
    assign w_ch_ok = (32'(ch) < 32'(CHANNELS));

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic w_hit;
            assign w_hit = w_ch_ok && (ch == c_CH_W'(i));

            pwm_channel #(
                .WIDTH (WIDTH),
                .POL   (POL_MASK[i])
            ) u_channel (
                .clk    (clk),
                .nrst   (nrst),
                .en     (en[i]),
                .wr_cmp (w_hit && (w_sel == SEL_CMP)),
                .wr_top (w_hit && (w_sel == SEL_TOP)),
                .wr_cnt (w_hit && (w_sel == SEL_CNT)),
                .d      (d),
                .out    (out[i]),
                .wrap   (wrap[i]),
                .cnt    (w_cnt[i])
            );
        end
    endgenerate

    // Out-of-range channel numbers read back as zero.
    assign cnt_rd = w_ch_ok ? w_cnt[ch] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Self-checking bench for pwm_multi (vector table, corner sequences,
//            random traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int             WIDTH = 16;
    localparam int             CH    = 4;
    localparam logic [CH-1:0]  c_POL = 4'b0100;

    logic             clk = 1'b0;
    logic             nrst;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic [1:0]       ch;
    logic [CH-1:0]    en;
    logic [CH-1:0]    out;
    logic [CH-1:0]    wrap;
    logic [WIDTH-1:0] cnt_rd;

    pwm_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CH),
        .POL_MASK (c_POL)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .d      (d),
        .sel    (sel),
        .ch     (ch),
        .en     (en),
        .out    (out),
        .cnt_rd (cnt_rd),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]       sel;
        logic [1:0]       ch;
        logic [WIDTH-1:0] d;
        logic [CH-1:0]    en;
        logic [CH-1:0]    exp_out;
        logic [CH-1:0]    exp_wrap;
        logic [WIDTH-1:0] exp_cnt;
    } vec_t;

    vec_t tbl [14];

    // Reference model: per-channel period position and register images.
    logic [WIDTH-1:0] m_cnt   [CH];
    logic [WIDTH-1:0] m_cmp_s [CH];
    logic [WIDTH-1:0] m_top_s [CH];
    logic [WIDTH-1:0] m_cmp_a [CH];
    logic [WIDTH-1:0] m_top_a [CH];
    logic [CH-1:0]    m_run;
    logic [CH-1:0]    m_out;
    logic [CH-1:0]    m_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]   = '0;
            m_cmp_s[i] = '0;
            m_top_s[i] = '0;
            m_cmp_a[i] = '0;
            m_top_a[i] = '0;
        end
        m_run  = '0;
        m_out  = c_POL;
        m_wrap = '0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] nc;
        logic [WIDTH-1:0] na;
        logic [WIDTH-1:0] nt;
        logic             nw;
        logic             hit;
        for (int i = 0; i < CH; i++) begin
            hit = (sel != 2'd0) && (ch == 2'(i));
            nc  = m_cnt[i];
            na  = m_cmp_a[i];
            nt  = m_top_a[i];
            nw  = 1'b0;
            if (!en[i]) begin
                nc = '0;
                na = m_cmp_s[i];
                nt = m_top_s[i];
            end else if (!m_run[i]) begin
                na = m_cmp_s[i];
                nt = m_top_s[i];
            end else if (m_cnt[i] >= m_top_a[i]) begin
                nc = '0;
                na = m_cmp_s[i];
                nt = m_top_s[i];
                nw = 1'b1;
            end else begin
                nc = m_cnt[i] + 16'd1;
            end
            if (hit && sel == 2'd3) nc = d;
            if (hit && sel == 2'd1) m_cmp_s[i] = d;
            if (hit && sel == 2'd2) m_top_s[i] = d;
            m_cnt[i]   = nc;
            m_cmp_a[i] = na;
            m_top_a[i] = nt;
            m_wrap[i]  = nw;
            m_out[i]   = en[i] ? ((nc < na) ^ c_POL[i]) : c_POL[i];
            m_run[i]   = en[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_out",  32'(out),    32'(m_out));
        check("model_wrap", 32'(wrap),   32'(m_wrap));
        check("model_cnt",  32'(cnt_rd), 32'(m_cnt[ch]));
    endtask

    task automatic drive(input logic [1:0] s, input logic [1:0] c, input logic [WIDTH-1:0] v);
        sel = s;
        ch  = c;
        d   = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi;
        int          bad;
        int          found;
        logic [9:0]  pat;

        // {sel, ch, d, en, out, wrap, cnt_rd}
        tbl[0]  = '{2'd2, 2'd0, 16'd9, 4'b0000, 4'b0100, 4'b0000, 16'd0};
        tbl[1]  = '{2'd1, 2'd0, 16'd3, 4'b0000, 4'b0100, 4'b0000, 16'd0};
        tbl[2]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0101, 4'b0000, 16'd0};
        tbl[3]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0101, 4'b0000, 16'd1};
        tbl[4]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0101, 4'b0000, 16'd2};
        tbl[5]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd3};
        tbl[6]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd4};
        tbl[7]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd5};
        tbl[8]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd6};
        tbl[9]  = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd7};
        tbl[10] = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd8};
        tbl[11] = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0100, 4'b0000, 16'd9};
        tbl[12] = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0101, 4'b0001, 16'd0};
        tbl[13] = '{2'd0, 2'd0, 16'd0, 4'b0001, 4'b0101, 4'b0000, 16'd1};

        nrst = 1'b1;
        drive(2'd0, 2'd0, '0);
        en = 4'b1111;
        model_reset();
        #3 nrst = 1'b0;
        #1;
        check("reset_out",  32'(out),    32'(c_POL));
        check("reset_wrap", 32'(wrap),   32'd0);
        check("reset_cnt",  32'(cnt_rd), 32'd0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        repeat (4) tick();
        check("top0_wrap_every_cycle", 32'(wrap), 32'hF);
        check("cmp0_inactive",         32'(out),  32'(c_POL));

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].sel, tbl[i].ch, tbl[i].d);
            en = tbl[i].en;
            tick();
            check($sformatf("tbl%0d_out", i),  32'(out),    32'(tbl[i].exp_out));
            check($sformatf("tbl%0d_wrap", i), 32'(wrap),   32'(tbl[i].exp_wrap));
            check($sformatf("tbl%0d_cnt", i),  32'(cnt_rd), 32'(tbl[i].exp_cnt));
        end

        // Mid-period compare change on ch1 waits for the wrap.
        drive(2'd2, 2'd1, 16'd9); tick();
        drive(2'd1, 2'd1, 16'd3); tick();
        drive(2'd0, 2'd1, 16'd0);
        en = 4'b0011;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) drive(2'd1, 2'd1, 16'd7);
            tick();
            if (k == 4) drive(2'd0, 2'd1, 16'd0);
            hi += int'(out[1]);
        end
        check("ch1_old_duty", hi, 3);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            hi += int'(out[1]);
        end
        check("ch1_new_duty", hi, 7);

        // ch2 is inverted: cmp=0 holds it at 1, cmp>top holds it at 0.
        drive(2'd2, 2'd2, 16'd9); tick();
        drive(2'd1, 2'd2, 16'd0); tick();
        drive(2'd0, 2'd2, 16'd0);
        en = 4'b0111;
        bad = 0;
        repeat (12) begin
            tick();
            if (out[2] !== 1'b1) bad++;
        end
        check("ch2_cmp0_level", bad, 0);
        drive(2'd1, 2'd2, 16'd20);
        en = 4'b0011;
        tick();
        drive(2'd0, 2'd2, 16'd0);
        en = 4'b0111;
        bad = 0;
        repeat (12) begin
            tick();
            if (out[2] !== 1'b0) bad++;
        end
        check("ch2_cmp_gt_top_level", bad, 0);

        // Counter writes on ch0 (top=9).
        drive(2'd3, 2'd0, 16'd15); tick();
        check("cnt_wr_visible", 32'(cnt_rd), 32'd15);
        drive(2'd0, 2'd0, 16'd0); tick();
        check("cnt_over_top_wrap", 32'(wrap[0]), 32'd1);
        check("cnt_over_top_zero", 32'(cnt_rd),  32'd0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (cnt_rd == 16'd9) found = 1;
        end
        check("reach_top_bounded", found, 1);
        drive(2'd3, 2'd0, 16'd5); tick();
        check("wr_on_wrap_cnt",  32'(cnt_rd),  32'd5);
        check("wr_on_wrap_wrap", 32'(wrap[0]), 32'd1);
        drive(2'd0, 2'd0, 16'd0);

        // ch3: disable mid-period, reprogram, re-enable.
        drive(2'd2, 2'd3, 16'd9); tick();
        drive(2'd1, 2'd3, 16'd5); tick();
        drive(2'd0, 2'd3, 16'd0);
        en = 4'b1111;
        repeat (4) tick();
        en = 4'b0111;
        drive(2'd2, 2'd3, 16'd4); tick();
        drive(2'd1, 2'd3, 16'd2); tick();
        drive(2'd0, 2'd3, 16'd0);
        en = 4'b1111;
        pat = '0;
        repeat (10) begin
            tick();
            pat = {pat[8:0], out[3]};
        end
        check("ch3_reenable_pattern", 32'(pat), 32'(10'b1100011000));

        // Asynchronous reset between edges.
        #2 nrst = 1'b0;
        #1;
        check("async_rst_out",  32'(out),    32'(c_POL));
        check("async_rst_wrap", 32'(wrap),   32'd0);
        check("async_rst_cnt",  32'(cnt_rd), 32'd0);
        model_reset();
        @(posedge clk);
        #1 nrst = 1'b1;

        for (int k = 0; k < 400; k++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 14)));
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
